// File: rtl/rtype_ctrl_fsm.sv
// Multi-cycle control sequencer for the R-type datapath: fetch handshake, IR latch,
// ADD/SUB/OR/AND decode, one-cycle write/PC strobes, sticky traps and retire counter.
module rtype_ctrl_fsm #(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instr_code,
  output logic [31:0]      ir,
  output logic [1:0]       alu_op,
  output logic             reg_file_we,
  output logic             pc_en,
  output logic             illegal,
  output logic             fetch_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    TRAP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [31:0]      ir_n;
  logic [1:0]       alu_op_n;
  logic             illegal_n, fetch_timeout_n;
  logic [CNT_W-1:0] retired_n;
  logic             dec_ok;
  logic [1:0]       dec_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      ir            <= '0;
      alu_op        <= '0;
      illegal       <= 1'b0;
      fetch_timeout <= 1'b0;
      retired       <= '0;
    end else begin
      state         <= state_n;
      tcnt          <= tcnt_n;
      ir            <= ir_n;
      alu_op        <= alu_op_n;
      illegal       <= illegal_n;
      fetch_timeout <= fetch_timeout_n;
      retired       <= retired_n;
    end
  end

  // Key is {funct7, funct3}; only the four supported R-type encodings are legal.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = alu_op;
    if (ir[6:0] == 7'b0110011) begin
      case ({ir[31:25], ir[14:12]})
        10'b0000000_000: begin dec_ok = 1'b1; dec_op = 2'b00; end
        10'b0100000_000: begin dec_ok = 1'b1; dec_op = 2'b01; end
        10'b0000000_110: begin dec_ok = 1'b1; dec_op = 2'b10; end
        10'b0000000_111: begin dec_ok = 1'b1; dec_op = 2'b11; end
        default:         dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_n         = state;
    tcnt_n          = tcnt;
    ir_n            = ir;
    alu_op_n        = alu_op;
    illegal_n       = illegal;
    fetch_timeout_n = fetch_timeout;
    retired_n       = retired;
    case (state)
      IDLE: begin
        if (run) state_n = FETCH;
      end
      FETCH: begin
        // Ready on the final allowed cycle wins over the timeout.
        if (imem_ready) begin
          ir_n    = instr_code;
          tcnt_n  = '0;
          state_n = DECODE;
        end else if (tcnt == TW'(FETCH_TIMEOUT - 1)) begin
          tcnt_n          = '0;
          fetch_timeout_n = 1'b1;
          state_n         = TRAP;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      DECODE: begin
        if (dec_ok) begin
          alu_op_n = dec_op;
          state_n  = EXEC;
        end else begin
          illegal_n = 1'b1;
          state_n   = TRAP;
        end
      end
      EXEC: begin
        retired_n = retired + CNT_W'(1);
        state_n   = run ? FETCH : IDLE;
      end
      TRAP:    state_n = TRAP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    pc_en       = (state == EXEC);
    reg_file_we = (state == EXEC) && (ir[11:7] != 5'd0);
    busy        = (state != IDLE) && (state != TRAP);
  end

endmodule

// File: doc/rtype_ctrl_fsm.md
Name: rtype_ctrl_fsm

Overview:
Multi-cycle control sequencer for the R-type single-cycle datapath (register file + ALU + PC register/adder). It fetches each instruction through a request/ready handshake and latches it into an instruction register (IR) that feeds the datapath's rs1/rs2/rd fields. It decodes ADD/SUB/OR/AND into the 2-bit ALU opcode and issues one-cycle register-file write and PC-advance strobes. Illegal opcodes and fetch timeouts are trapped, and retired instructions are counted.

Parameters:
FETCH_TIMEOUT, 15, max consecutive FETCH cycles without imem_ready before a trap (>=1).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  level; 1 = keep executing, 0 = stop after the current instruction.
imem_req  output  1  fetch request to instruction memory.
imem_ready  input  1  instr_code is valid this cycle; sampled only while imem_req=1.
instr_code  input  32  instruction word from instruction memory.
ir  output  32  latched instruction; drives datapath rAddr1=ir[19:15], rAddr2=ir[24:20], wAddr=ir[11:7].
alu_op  output  2  00 ADD, 01 SUB, 10 OR, 11 AND (registered).
reg_file_we  output  1  register-file write strobe.
pc_en  output  1  PC load enable (PC <= PC+4 when 1).
illegal  output  1  sticky trap flag, unsupported instruction.
fetch_timeout  output  1  sticky trap flag, imem_ready missing.
busy  output  1  1 in any state except IDLE and TRAP.
retired  output  CNT_W  count of executed instructions.

Behaviour:
- Reset (async, rst=1): state=IDLE; ir=0, alu_op=00, all strobes 0, illegal=0, fetch_timeout=0, retired=0, timeout counter=0. Reset mid-operation aborts immediately with no partial write.
- States: IDLE, FETCH, DECODE, EXEC, TRAP. All state and outputs are registered; reg_file_we, pc_en, imem_req and busy are decoded from state only.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH: imem_req=1, timeout counter increments each cycle.
  - imem_ready=1: ir<=instr_code, counter cleared, -> DECODE.
  - Counter reaches FETCH_TIMEOUT with no ready: fetch_timeout<=1, -> TRAP.
  - Ready on the last allowed cycle counts as success.
  - run falling during FETCH does not abort the fetch.
- DECODE: legal only when opcode ir[6:0]=0110011 and (funct7, funct3) is one of:
  - (0000000, 000) ADD -> alu_op 00
  - (0100000, 000) SUB -> alu_op 01
  - (0000000, 110) OR -> alu_op 10
  - (0000000, 111) AND -> alu_op 11
  - Legal: alu_op is loaded, -> EXEC.
  - Anything else: illegal<=1, alu_op unchanged, -> TRAP.
- EXEC (exactly 1 cycle):
  - pc_en=1.
  - reg_file_we=1 unless ir[11:7]=0; x0 writes are suppressed, but the instruction still retires.
  - retired increments and wraps from all-ones to 0.
  - Next state is FETCH if run=1, else IDLE.
- Latency: with imem_ready in the first FETCH cycle, one instruction takes 3 cycles (FETCH, DECODE, EXEC). Each wait cycle in FETCH adds one cycle.
- alu_op holds its value from the last legal DECODE through IDLE and TRAP.
- TRAP: absorbing; all strobes 0, flags held, no pc_en, no write. Only rst exits.
- run toggling in DECODE/EXEC is ignored until the EXEC next-state decision.

Test Plan:
- Reset then run=1, imem_ready=1 every FETCH cycle, instr 0x002081B3 (ADD x3,x1,x2) -> alu_op=00 from cycle 3; reg_file_we=1 and pc_en=1 in cycle 3 only; retired=1; ir=0x002081B3.
- Back-to-back stream 0x407302B3 (SUB), 0x0020E233 (OR), 0x0020F233 (AND) -> alu_op 01, 10, 11; one EXEC every 3 cycles; retired=3; pc_en pulses 3 times.
- 0x00208033 (ADD x0) -> reg_file_we stays 0, pc_en=1, retired increments.
- 0x00000013 (ADDI) -> illegal=1 after DECODE, state TRAP, no further imem_req or pc_en until rst; then rst clears illegal to 0.
- imem_ready held 0 for 15 FETCH cycles -> fetch_timeout=1 and TRAP. Ready arriving on FETCH cycle 15 -> normal DECODE.
- run dropped during FETCH with 3 ready-wait cycles -> the instruction completes and the FSM enters IDLE with busy=0. Assert rst during EXEC -> reg_file_we=0 immediately and all outputs return to reset values.
